comma_aligner: RTL and testbench
================================

Name: comma_aligner

Overview:
- Parametrised receive-side word aligner for the 8b/10b link.
- Takes raw 10-bit parallel words at arbitrary bit phase from the deserializer.
- Hunts for the K28.5 comma at any of 10 bit offsets, then qualifies lock with a configurable comma count.
- Presents symbol-aligned 10-bit codes to the 8b/10b decoder and drops lock after repeated misaligned commas.

Parameters:
- LOCK_CNT, 3: consecutive commas at one offset required to declare lock (1..15).
- LOSS_CNT, 4: consecutive commas at a foreign offset that force loss of lock (1..15).
- BOTH_RD, 1: 1 = accept K28.5 of either running disparity; 0 = RD- form only.

Ports:
- pclk  input  1  parallel word clock; all logic on rising edge.
- reset_n  input  1  synchronous reset, active low.
- raw_in  input  10  raw deserialized word; bit 9 is first received bit ('a').
- raw_valid  input  1  raw_in valid this cycle.
- realign  input  1  pulse: drop lock and re-hunt.
- sym_out  output  10  aligned symbol, bit 9 = 'a'.
- sym_valid  output  1  sym_out valid (locked only).
- sym_is_comma  output  1  sym_out is K28.5.
- locked  output  1  alignment locked.
- offset  output  4  current bit offset, 0..9.
- lock_lost  output  1  one-cycle pulse on LOCKED->HUNT transition.

Behaviour:
- Reset (reset_n=0 at pclk edge): state=HUNT, prev word=0, offset=0, counters=0, sym_out=0, sym_valid=0, sym_is_comma=0, locked=0, lock_lost=0.
- Reset is synchronous: mid-operation it overrides every other input that cycle.
- Window: w[19:0] = {prev, raw_in}, evaluated only when raw_valid=1. prev <= raw_in on each valid cycle.
- Candidate k (k = 0..9) is w[19-k -: 10]. Each received bit position is examined exactly once.
- Comma match: candidate == 10'b0011111010 (RD-), or, when BOTH_RD=1, candidate == 10'b1100000101 (RD+).
- hit[k] is the match flag per offset. When several offsets hit, the lowest k wins (first_hit).
- raw_valid=0: no state, counter, prev or offset change. sym_valid=0 next cycle.
- FSM, evaluated on valid cycles:
  - HUNT: any hit -> offset<=first_hit, good_cnt<=1. Go to CHECK, or directly to LOCKED if LOCK_CNT=1.
  - CHECK:
    - hit[offset] -> good_cnt+1; on reaching LOCK_CNT go to LOCKED with bad_cnt<=0.
    - Hit only at other offsets -> offset<=first_hit, good_cnt<=1, stay in CHECK.
    - No hit -> hold.
  - LOCKED:
    - hit[offset] -> bad_cnt<=0.
    - Hit elsewhere without hit[offset] -> bad_cnt+1; on reaching LOSS_CNT go to HUNT, pulse lock_lost, clear counters.
    - No hit -> hold.
- realign=1 (reset_n=1): next state HUNT, counters cleared, offset held. lock_lost pulses only if the state was LOCKED. realign takes priority over any hit that cycle.
- Outputs, registered, 1-cycle latency from the raw_valid cycle:
  - sym_out <= w[19-off_next -: 10], where off_next is the offset after this cycle's update.
  - sym_valid <= raw_valid & (next state == LOCKED).
  - sym_is_comma <= hit[off_next] & raw_valid.
  - locked = (state == LOCKED).
- The symbol that completes lock is emitted with sym_valid=1.
- Counters saturate. Their width is derived to hold 15.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with random raw_in -> all outputs 0; locked=0, offset=0.
- Acquire at offset 3: stream a K28.5/D-symbol sequence shifted 3 bits, with commas every 4th word, LOCK_CNT=3 -> locked rises on the cycle after the 3rd comma. offset=3. sym_out reproduces the transmitted 10b codes; sym_is_comma=1 on the commas.
- Phase change in CHECK: 2 commas at offset 3, then a comma at offset 7 -> offset becomes 7; 3 more commas at 7 are needed for lock.
- Loss: while locked, inject 4 commas at offset 5, no offset-3 comma between -> lock_lost pulses once; locked=0 and sym_valid=0 from the next cycle; re-hunt locks at 5 after 3 commas. A single offset-3 comma interleaved resets bad_cnt, so no loss occurs.
- Gaps / realign: hold raw_valid=0 for 5 cycles mid-lock -> state held, sym_valid=0 during the gap. Assert realign while locked -> lock_lost=1 for one cycle, state HUNT.
- Reset mid-operation: drop reset_n while locked with a comma present at the inputs -> next cycle matches the reset values exactly; prev word cleared.

Source files
------------

// File: rtl/comma_aligner.sv
// comma_aligner: hunts K28.5 at any of 10 bit phases, qualifies lock, emits symbol-aligned codes
module comma_aligner #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4,
  parameter bit BOTH_RD  = 1'b1
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic [9:0] raw_in,
  input  logic       raw_valid,
  input  logic       realign,
  output logic [9:0] sym_out,
  output logic       sym_valid,
  output logic       sym_is_comma,
  output logic       locked,
  output logic [3:0] offset,
  output logic       lock_lost
);
  localparam logic [9:0] K_RDM  = 10'b0011111010;
  localparam logic [9:0] K_RDP  = 10'b1100000101;
  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t      r_state, w_state_n;
  logic [9:0]  r_prev, r_sym;
  logic [3:0]  r_off, w_off_n, r_good, w_good_n, r_bad, w_bad_n, w_first, w_ginc, w_binc;
  logic        r_valid, r_comma, r_lost, w_lost, w_any;
  logic [19:0] w_win, w_sh;
  logic [9:0]  w_hit;
  assign w_win = {r_prev, raw_in};
  for (genvar k = 0; k < 10; k++) begin : g_hit
    assign w_hit[k] = (w_win[19-k -: 10] == K_RDM) || (BOTH_RD && (w_win[19-k -: 10] == K_RDP));
  end
  assign w_any  = |w_hit;
  assign w_ginc = (r_good == 4'hF) ? r_good : r_good + 4'd1;
  assign w_binc = (r_bad == 4'hF) ? r_bad : r_bad + 4'd1;
  assign w_sh   = w_win >> (4'd10 - w_off_n);
  // lowest matching offset wins when several phases hit
  always_comb begin
    w_first = 4'd0;
    for (int i = 9; i >= 0; i--) if (w_hit[i]) w_first = 4'(i);
  end
  // next-state, offset and qualification counters; realign beats any hit
  always_comb begin
    w_state_n = r_state;
    w_off_n   = r_off;
    w_good_n  = r_good;
    w_bad_n   = r_bad;
    w_lost    = 1'b0;
    if (realign) begin
      w_state_n = HUNT;
      w_good_n  = 4'd0;
      w_bad_n   = 4'd0;
      w_lost    = (r_state == LOCKED);
    end else if (raw_valid) begin
      case (r_state)
        HUNT: if (w_any) begin
          w_off_n   = w_first;
          w_good_n  = 4'd1;
          w_bad_n   = 4'd0;
          w_state_n = (LOCK_N == 4'd1) ? LOCKED : CHECK;
        end
        CHECK: if (w_hit[r_off]) begin
          w_good_n = w_ginc;
          if (w_ginc >= LOCK_N) begin
            w_state_n = LOCKED;
            w_bad_n   = 4'd0;
          end
        end else if (w_any) begin
          w_off_n  = w_first;
          w_good_n = 4'd1;
        end
        LOCKED: if (w_hit[r_off]) w_bad_n = 4'd0;
        else if (w_any) begin
          w_bad_n = w_binc;
          if (w_binc >= LOSS_N) begin
            w_state_n = HUNT;
            w_lost    = 1'b1;
            w_good_n  = 4'd0;
            w_bad_n   = 4'd0;
          end
        end
        default: w_state_n = HUNT;
      endcase
    end
  end
  // state, window history and registered symbol outputs
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      r_state <= HUNT;
      r_prev  <= 10'd0;
      r_off   <= 4'd0;
      r_good  <= 4'd0;
      r_bad   <= 4'd0;
      r_sym   <= 10'd0;
      r_valid <= 1'b0;
      r_comma <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_off   <= w_off_n;
      r_good  <= w_good_n;
      r_bad   <= w_bad_n;
      r_valid <= raw_valid && (w_state_n == LOCKED);
      r_comma <= raw_valid && w_hit[w_off_n];
      r_lost  <= w_lost;
      if (raw_valid) begin
        r_prev <= raw_in;
        r_sym  <= w_sh[9:0];
      end
    end
  end
  assign sym_out      = r_sym;
  assign sym_valid    = r_valid;
  assign sym_is_comma = r_comma;
  assign locked       = (r_state == LOCKED);
  assign offset       = r_off;
  assign lock_lost    = r_lost;
endmodule

// File: tb/tb_comma_aligner.sv
// tb_comma_aligner: directed acquisition, phase change, loss, gap, realign and reset vectors
module tb_comma_aligner;
  localparam logic [9:0] KM = 10'b0011111010;
  localparam logic [9:0] DA = 10'b1010101010;
  localparam logic [9:0] DB = 10'b0101010101;
  localparam logic [9:0] DC = 10'b1001110100;
  logic       pclk = 1'b0, reset_n = 1'b0, raw_valid = 1'b0, realign = 1'b0;
  logic [9:0] raw_in = 10'd0, sym_out, tx_prev = DA, obs;
  logic       sym_valid, sym_is_comma, locked, lock_lost;
  logic [3:0] offset;
  int         n_chk = 0, n_pass = 0;
  always #5 pclk = ~pclk;
  comma_aligner dut (
    .pclk(pclk), .reset_n(reset_n), .raw_in(raw_in), .raw_valid(raw_valid), .realign(realign),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_is_comma(sym_is_comma), .locked(locked),
    .offset(offset), .lock_lost(lock_lost)
  );
  assign obs = {2'b00, locked, sym_valid, sym_is_comma, lock_lost, offset};
  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", tag, got, exp);
  endtask
  function automatic logic [9:0] stat(input bit l, input bit v, input bit c, input bit ll, input logic [3:0] o);
    return {2'b00, l, v, c, ll, o};
  endfunction
  task automatic tx(input string tag, input logic [9:0] s, input int k, input bit cs, input logic [9:0] es);
    logic [19:0] c;
    logic [9:0]  exp_sym;
    c = {tx_prev, s} >> k;
    exp_sym = tx_prev;
    tx_prev = s;
    @(negedge pclk);
    raw_in = c[9:0];
    raw_valid = 1'b1;
    @(posedge pclk);
    #1;
    chk({tag, " status"}, obs, es);
    if (cs && es[6]) chk({tag, " sym"}, sym_out, exp_sym);
  endtask
  task automatic idle(input string tag, input logic [9:0] es);
    @(negedge pclk);
    raw_valid = 1'b0;
    @(posedge pclk);
    #1;
    chk(tag, obs, es);
  endtask
  task automatic frame(input string tag, input int k, input int kn, input bit cs, input bit l0, input bit l1,
                       input bit c1, input bit ll1, input logic [3:0] o0, input logic [3:0] o1);
    tx({tag, " K"},  KM, k,  cs,            stat(l0, l0, 1'b0, 1'b0, o0));
    tx({tag, " DC"}, DC, k,  cs,            stat(l1, l1, c1,   ll1,  o1));
    tx({tag, " DA"}, DA, k,  cs,            stat(l1, l1, 1'b0, 1'b0, o1));
    tx({tag, " DB"}, DB, kn, cs && kn == k, stat(l1, l1, 1'b0, 1'b0, o1));
  endtask
  initial begin
    repeat (2) begin
      @(negedge pclk);
      raw_in = 10'($urandom);
      raw_valid = 1'($urandom);
      @(posedge pclk);
      #1;
      chk("reset status", obs, 10'd0);
      chk("reset sym", sym_out, 10'd0);
    end
    @(negedge pclk);
    reset_n = 1'b1;
    raw_valid = 1'b0;
    frame("acq1", 3, 3, 1, 0, 0, 1, 0, 0, 3);
    frame("acq2", 3, 3, 1, 0, 0, 1, 0, 3, 3);
    frame("acq3", 3, 3, 1, 0, 1, 1, 0, 3, 3);
    repeat (5) idle("gap", stat(1, 0, 0, 0, 3));
    frame("post_gap", 3, 5, 1, 1, 1, 1, 0, 3, 3);
    frame("bad1", 5, 5, 0, 1, 1, 0, 0, 3, 3);
    frame("bad2", 5, 5, 0, 1, 1, 0, 0, 3, 3);
    frame("bad3", 5, 3, 0, 1, 1, 0, 0, 3, 3);
    frame("good_mid", 3, 5, 1, 1, 1, 1, 0, 3, 3);
    frame("bad_b1", 5, 5, 0, 1, 1, 0, 0, 3, 3);
    frame("bad_b2", 5, 5, 0, 1, 1, 0, 0, 3, 3);
    frame("bad_b3", 5, 5, 0, 1, 1, 0, 0, 3, 3);
    frame("loss", 5, 5, 0, 1, 0, 0, 1, 3, 3);
    frame("rehunt1", 5, 5, 1, 0, 0, 1, 0, 3, 5);
    frame("rehunt2", 5, 5, 1, 0, 0, 1, 0, 5, 5);
    frame("rehunt3", 5, 3, 1, 0, 1, 1, 0, 5, 5);
    realign = 1'b1;
    idle("realign", stat(0, 0, 0, 1, 5));
    realign = 1'b0;
    idle("realign_clr", stat(0, 0, 0, 0, 5));
    frame("ph1", 3, 3, 1, 0, 0, 1, 0, 5, 3);
    frame("ph2", 3, 7, 1, 0, 0, 1, 0, 3, 3);
    frame("ph3", 7, 7, 1, 0, 0, 1, 0, 3, 7);
    frame("ph4", 7, 7, 1, 0, 0, 1, 0, 7, 7);
    frame("ph5", 7, 7, 1, 0, 1, 1, 0, 7, 7);
    tx("rp K", KM, 7, 1, stat(1, 1, 0, 0, 7));
    realign = 1'b1;
    tx("rp DC", DC, 7, 1, stat(0, 0, 1, 1, 7));
    realign = 1'b0;
    tx("rp DA", DA, 7, 1, stat(0, 0, 0, 0, 7));
    tx("rp DB", DB, 7, 1, stat(0, 0, 0, 0, 7));
    frame("rp1", 7, 7, 1, 0, 0, 1, 0, 7, 7);
    frame("rp2", 7, 7, 1, 0, 0, 1, 0, 7, 7);
    frame("rp3", 7, 7, 1, 0, 1, 1, 0, 7, 7);
    tx("mr K", KM, 7, 1, stat(1, 1, 0, 0, 7));
    reset_n = 1'b0;
    tx("mr DC", DC, 7, 0, 10'd0);
    chk("mr sym", sym_out, 10'd0);
    reset_n = 1'b1;
    tx("mr DA", DA, 7, 0, stat(0, 0, 0, 0, 0));
    chk("mr prev", sym_out, 10'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
